spi_frame_decoder: RTL and testbench

Receive-side front end for the SPI control path: samples the raw nCS/COPI/SCLK pins from `ui_in[2:0]` into the `clk` domain, assembles 16-bit MSB-first frames, validates them, and emits a one-cycle write strobe with a 7-bit address and 8-bit data. It sits directly upstream of the control register bank that drives the PWM peripheral's enable and duty-cycle registers. That bank consumes only `wr_valid`, `wr_addr` and `wr_data`.

---
 rtl/spi_frame_decoder_if.sv | 35 +++
 rtl/spi_frame_decoder.sv | 184 ++++++++++++++++++
 tb/tb_spi_frame_decoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_decoder_if.sv
// Bundle of the raw SPI pins and the decoded write-strobe outputs of
// spi_frame_decoder. The slave modport is the decoder's view; the master
// modport is the view of whatever drives the pins and consumes the strobe.
interface spi_frame_decoder_if;
  logic       ncs;
  logic       copi;
  logic       sclk;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [7:0] err_count;

  modport slave (
    input  ncs,
    input  copi,
    input  sclk,
    output wr_valid,
    output wr_addr,
    output wr_data,
    output frame_err,
    output err_count
  );

  modport master (
    output ncs,
    output copi,
    output sclk,
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  frame_err,
    input  err_count
  );
endinterface

// File: rtl/spi_frame_decoder.sv
// SPI (mode 0) receive front end: synchronizes raw nCS/COPI/SCLK into clk,
// assembles 16-bit MSB-first frames {rw, addr[6:0], data[7:0]} and emits a
// one-cycle write strobe or a one-cycle frame error.
// Optional feature macro: SPI_FRAME_ERR_CNT_EN builds the saturating
// rejected-frame counter; without it err_count is tied to zero.
// Edge pulses are registered once after the history flop, so a strobe
// appears SYNC_STAGES+1 cycles after the first edge that samples nCS high.
module spi_frame_decoder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] ADDR_MAX    = 7'h04
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_frame_decoder_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_OVR  = 5'd17;

  logic [SYNC_STAGES-1:0] ncs_sync_r;
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] copi_sync_r;
  logic                   ncs_hist_r;
  logic                   sclk_hist_r;
  logic                   ncs_fall_r;
  logic                   ncs_rise_r;
  logic                   sclk_rise_r;
  logic                   copi_bit_r;

  state_t                 state_r;
  logic [15:0]            shift_r;
  logic [4:0]             bit_cnt_r;
  logic                   wr_valid_r;
  logic [6:0]             wr_addr_r;
  logic [7:0]             wr_data_r;
  logic                   frame_err_r;

  logic                   frame_end_s;
  logic                   full_frame_s;
  logic                   accept_s;
  logic                   drop_s;
  logic                   reject_s;

  // Input synchronizers, idle levels on reset (nCS high, SCLK/COPI low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_sync_r  <= {SYNC_STAGES{1'b1}};
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      copi_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], bus.ncs};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.sclk};
      copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], bus.copi};
    end
  end

  // History flops and registered edge pulses; COPI is delayed alongside so it
  // stays aligned with the SCLK rise pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_hist_r  <= 1'b1;
      sclk_hist_r <= 1'b0;
      ncs_fall_r  <= 1'b0;
      ncs_rise_r  <= 1'b0;
      sclk_rise_r <= 1'b0;
      copi_bit_r  <= 1'b0;
    end else begin
      ncs_hist_r  <= ncs_sync_r[SYNC_STAGES-1];
      sclk_hist_r <= sclk_sync_r[SYNC_STAGES-1];
      ncs_fall_r  <= ncs_hist_r & ~ncs_sync_r[SYNC_STAGES-1];
      ncs_rise_r  <= ~ncs_hist_r & ncs_sync_r[SYNC_STAGES-1];
      sclk_rise_r <= ~sclk_hist_r & sclk_sync_r[SYNC_STAGES-1];
      copi_bit_r  <= copi_sync_r[SYNC_STAGES-1];
    end
  end

  // Frame classification at the end of a frame (nCS rising while shifting).
  always_comb begin
    frame_end_s  = 1'b0;
    full_frame_s = 1'b0;
    accept_s     = 1'b0;
    drop_s       = 1'b0;
    reject_s     = 1'b0;
    if ((state_r == ST_SHIFT) && ncs_rise_r) begin
      frame_end_s  = 1'b1;
      full_frame_s = (bit_cnt_r == CNT_FULL);
      if (full_frame_s && !shift_r[15]) begin
        drop_s = 1'b1;
      end else if (full_frame_s && (shift_r[14:8] <= ADDR_MAX)) begin
        accept_s = 1'b1;
      end else begin
        reject_s = 1'b1;
      end
    end else begin
      frame_end_s = 1'b0;
    end
  end

  // Frame FSM with shift register, saturating bit counter and strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      shift_r     <= 16'h0000;
      bit_cnt_r   <= 5'd0;
      wr_valid_r  <= 1'b0;
      wr_addr_r   <= 7'h00;
      wr_data_r   <= 8'h00;
      frame_err_r <= 1'b0;
    end else begin
      wr_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // SCLK edges here (including one coincident with nCS falling) are
          // ignored: the frame starts from a cleared shift register.
          if (ncs_fall_r) begin
            state_r   <= ST_SHIFT;
            shift_r   <= 16'h0000;
            bit_cnt_r <= 5'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // nCS rising wins over a coincident SCLK edge.
          if (frame_end_s) begin
            state_r <= ST_IDLE;
            if (accept_s) begin
              wr_valid_r <= 1'b1;
              wr_addr_r  <= shift_r[14:8];
              wr_data_r  <= shift_r[7:0];
            end else if (reject_s) begin
              frame_err_r <= 1'b1;
            end else begin
              wr_valid_r <= 1'b0;
            end
          end else if (sclk_rise_r) begin
            shift_r <= {shift_r[14:0], copi_bit_r};
            if (bit_cnt_r != CNT_OVR) begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
            end else begin
              bit_cnt_r <= CNT_OVR;
            end
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SPI_FRAME_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  // Saturating count of rejected frames, stepping with the frame_err edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'h00;
    end else if (reject_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'h01;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign bus.err_count = err_cnt_r;
`else
  assign bus.err_count = 8'h00;
`endif

  assign bus.wr_valid  = wr_valid_r;
  assign bus.wr_addr   = wr_addr_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed, table-driven bench for spi_frame_decoder.
module tb_spi_frame_decoder;

  localparam int S = 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   strobe_cnt;
  int   err_pulses;
  logic both_seen;
  logic [14:0] strobe_log [16];
  logic [7:0]  exp_errcnt;
  logic [6:0]  exp_addr;
  logic [7:0]  exp_data;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic        exp_valid;
    logic        exp_err;
    logic [6:0]  new_addr;
    logic [7:0]  new_data;
  } vec_t;

  vec_t vecs [8];

  spi_frame_decoder_if bus ();

  spi_frame_decoder #(.SYNC_STAGES(S), .ADDR_MAX(7'h04)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record strobes and error pulses as seen at the falling edge.
  always @(negedge clk) begin
    if (bus.wr_valid) begin
      strobe_log[strobe_cnt & 15] <= {bus.wr_addr, bus.wr_data};
      strobe_cnt <= strobe_cnt + 1;
    end
    if (bus.frame_err) err_pulses <= err_pulses + 1;
    if (bus.wr_valid && bus.frame_err) both_seen <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Send nbits of data MSB first; returns at the falling clk edge where nCS rises.
  task automatic send_frame(input logic [31:0] data, input int nbits);
    @(negedge clk);
    bus.ncs = 1'b0;
    wait_cyc(3);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.copi = data[i];
      wait_cyc(3);
      bus.sclk = 1'b1;
      wait_cyc(3);
      bus.sclk = 1'b0;
    end
    wait_cyc(3);
    bus.ncs = 1'b1;
  endtask

  // Send one frame and check strobe/error timing cycle by cycle, then the held outputs.
  task automatic run_vec(input vec_t v);
    logic exp_v;
    logic exp_e;
    send_frame(v.bits, v.nbits);
    for (int k = 0; k <= S + 3; k++) begin
      @(negedge clk);
      exp_v = (k == S + 1) && v.exp_valid;
      exp_e = (k == S + 1) && v.exp_err;
      chk("wr_valid_timing", {31'd0, bus.wr_valid}, {31'd0, exp_v});
      chk("frame_err_timing", {31'd0, bus.frame_err}, {31'd0, exp_e});
    end
    if (v.exp_valid) begin
      exp_addr = v.new_addr;
      exp_data = v.new_data;
    end
`ifdef SPI_FRAME_ERR_CNT_EN
    if (v.exp_err && exp_errcnt != 8'hFF) exp_errcnt = exp_errcnt + 8'h01;
`endif
    chk("wr_addr", {25'd0, bus.wr_addr}, {25'd0, exp_addr});
    chk("wr_data", {24'd0, bus.wr_data}, {24'd0, exp_data});
    chk("err_count", {24'd0, bus.err_count}, {24'd0, exp_errcnt});
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_wr_valid"}, {31'd0, bus.wr_valid}, 32'd0);
    chk({tag, "_wr_addr"}, {25'd0, bus.wr_addr}, 32'd0);
    chk({tag, "_wr_data"}, {24'd0, bus.wr_data}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, bus.frame_err}, 32'd0);
    chk({tag, "_err_count"}, {24'd0, bus.err_count}, 32'd0);
  endtask

  initial begin
    int s0;
    int e0;
    vec_t rv;
    n_cmp = 0;
    n_bad = 0;
    strobe_cnt = 0;
    err_pulses = 0;
    both_seen = 1'b0;
    exp_errcnt = 8'h00;
    exp_addr = 7'h00;
    exp_data = 8'h00;

    vecs[0] = '{32'h0000_82A5, 16, 1'b1, 1'b0, 7'h02, 8'hA5};
    vecs[1] = '{32'h0000_1234, 15, 1'b0, 1'b1, 7'h00, 8'h00};
    vecs[2] = '{32'h0001_82A5, 17, 1'b0, 1'b1, 7'h00, 8'h00};
    vecs[3] = '{32'h0000_85FF, 16, 1'b0, 1'b1, 7'h00, 8'h00};
    vecs[4] = '{32'h0000_0312, 16, 1'b0, 1'b0, 7'h00, 8'h00};
    vecs[5] = '{32'h0000_8404, 16, 1'b1, 1'b0, 7'h04, 8'h04};
    vecs[6] = '{32'h0000_0000, 0,  1'b0, 1'b1, 7'h00, 8'h00};
    vecs[7] = '{32'h000F_FFFF, 20, 1'b0, 1'b1, 7'h00, 8'h00};

    bus.ncs = 1'b1;
    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    rst_n = 1'b0;
    wait_cyc(3);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    wait_cyc(3);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of a frame: partial frame is discarded.
    @(negedge clk);
    bus.ncs = 1'b0;
    wait_cyc(3);
    for (int i = 0; i < 8; i++) begin
      bus.copi = 1'b1;
      wait_cyc(3);
      bus.sclk = 1'b1;
      wait_cyc(3);
      bus.sclk = 1'b0;
    end
    rst_n = 1'b0;
    bus.ncs = 1'b1;
    bus.copi = 1'b0;
    wait_cyc(2);
    chk_zero_outputs("midreset");
    rst_n = 1'b1;
    exp_addr = 7'h00;
    exp_data = 8'h00;
    exp_errcnt = 8'h00;
    wait_cyc(3);
    rv = '{32'h0000_8410, 16, 1'b1, 1'b0, 7'h04, 8'h10};
    run_vec(rv);

    // Back-to-back writes with nCS high for the minimum two clk periods.
    s0 = strobe_cnt;
    send_frame(32'h0000_8001, 16);
    wait_cyc(1);
    send_frame(32'h0000_8180, 16);
    wait_cyc(S + 4);
    chk("b2b_strobe_count", strobe_cnt - s0, 32'd2);
    chk("b2b_first", {17'd0, strobe_log[s0 & 15]}, {17'd0, 7'h00, 8'h01});
    chk("b2b_second", {17'd0, strobe_log[(s0 + 1) & 15]}, {17'd0, 7'h01, 8'h80});

    // 260 short frames: counter saturation (or constant zero without the counter).
    e0 = err_pulses;
    s0 = strobe_cnt;
    for (int i = 0; i < 260; i++) begin
      send_frame(32'h0000_0001, 1);
      wait_cyc(2);
    end
    wait_cyc(S + 4);
    chk("short_err_pulses", err_pulses - e0, 32'd260);
    chk("short_no_strobe", strobe_cnt - s0, 32'd0);
`ifdef SPI_FRAME_ERR_CNT_EN
    chk("err_count_sat", {24'd0, bus.err_count}, 32'h0000_00FF);
`else
    chk("err_count_zero", {24'd0, bus.err_count}, 32'd0);
`endif
    chk("addr_held", {25'd0, bus.wr_addr}, {25'd0, 7'h01});
    chk("data_held", {24'd0, bus.wr_data}, {24'd0, 8'h80});
    chk("never_both_high", {31'd0, both_seen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
